// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter and baud generator among NREQ requesters.
// Optional even parity bit: define UART_TX_PARITY_EN.
module uart_tx_sched #(
    parameter int NREQ      = 4,
    parameter int SRC_W     = 2,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [SRC_W-1:0]     src_id,
    output logic                 busy,
    output logic                 done,
    output logic                 bps_start,
    input  logic                 clk_bps,
    output logic                 txd
);

`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int         FRAME_BITS = 10 + PAR_BITS + STOP_BITS - 1;
    localparam logic [3:0] LAST_CNT   = 4'(FRAME_BITS);
    localparam logic [3:0] DATA_END   = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t            state_q,     state_d;
    logic [SRC_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [SRC_W-1:0]  src_id_q,    src_id_d;
    logic [7:0]        shift_q,     shift_d;
    logic [3:0]        bit_cnt_q,   bit_cnt_d;
    logic [NREQ-1:0]   gnt_q,       gnt_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              bps_start_q, bps_start_d;
    logic              txd_q,       txd_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q,    parity_d;
`endif

    logic              arb_found;
    logic [SRC_W-1:0]  arb_idx;
    logic [NREQ-1:0]   arb_onehot;
    logic [7:0]        arb_byte;
    logic              strobe_ok;

    // Scan rr_ptr+1, rr_ptr+2, ... wrapping at NREQ; the first set request wins.
    always_comb begin : arbiter
        int               cand;
        logic [SRC_W-1:0] cand_idx;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cand       = 0;
        cand_idx   = '0;
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_onehot = '0;
        arb_byte   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = SRC_W'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == SRC_W'(i)) begin
                arb_onehot[i] = 1'b1;
                arb_byte      = req_data[8*i +: 8];
            end
        end
    end

    // The grant cycle itself never consumes a strobe.
    assign strobe_ok = clk_bps && bps_start_q && !(|gnt_q);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        src_id_d    = src_id_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bps_start_d = bps_start_q;
        txd_d       = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    rr_ptr_d    = arb_idx;
                    src_id_d    = arb_idx;
                    shift_d     = arb_byte;
                    bit_cnt_d   = '0;
                    gnt_d       = arb_onehot;
                    busy_d      = 1'b1;
                    bps_start_d = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d    = 1'b0;
`endif
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (strobe_ok) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd0) begin
                        txd_d = 1'b0;
                    end else if (bit_cnt_q <= DATA_END) begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b1, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
                        parity_d = parity_q ^ shift_q[0];
                    end else if (bit_cnt_q == 4'd9) begin
                        txd_d = parity_q;
`endif
                    end else if (bit_cnt_q < LAST_CNT) begin
                        txd_d = 1'b1;
                    end else begin
                        // This strobe closes the last stop bit.
                        txd_d       = 1'b1;
                        bps_start_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= SRC_W'(NREQ - 1);
            src_id_q    <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bps_start_q <= 1'b0;
            txd_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            src_id_q    <= src_id_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bps_start_q <= bps_start_d;
            txd_q       <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign src_id    = src_id_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bps_start = bps_start_q;
    assign txd       = txd_q;

endmodule
